// File: rtl/video_pkg.sv
// Shared types and defaults for the line-doubling scan converter.
package video_pkg;

  localparam int unsigned PIX_W = 8;
  // Line buffer word: {blank, palette index}
  localparam int unsigned LB_W  = PIX_W + 1;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned HS_LEN_DEF = 54;

  typedef struct packed {
    logic             blank;
    logic [PIX_W-1:0] pix;
  } lb_word_t;

endpackage

// File: rtl/video_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, two banks of 2**ADDR_W words,
// registered read, no reset on contents so it maps onto block RAM.
module video_linebuf
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W:0]   i_waddr,
  input  logic [LB_W-1:0]   i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W:0]   i_raddr,
  output logic [LB_W-1:0]   o_rdata
);

  localparam int unsigned Words = 2 ** (ADDR_W + 1);

  logic [LB_W-1:0] r_mem [Words];
  logic [LB_W-1:0] r_rdata;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; holds its value between read enables
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/video_scan_dbl.sv
// Line-doubling scan converter: captures a TV line at the c3 strobe into one
// bank of the line buffer while replaying the previous line twice at the f0
// strobe from the other bank.
module video_scan_dbl
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned HS_LEN = HS_LEN_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_c3,
  input  logic             i_f0,
  input  logic             i_tv_line_stb,
  input  logic [PIX_W-1:0] i_vplex_in,
  input  logic             i_tv_blank,
  output logic [PIX_W-1:0] o_vgaplex,
  output logic             o_vga_blank,
  output logic             o_vga_line,
  output logic             o_vga_hs,
  output logic             o_ovf
);

  localparam int unsigned        CntW  = ADDR_W + 1;
  localparam logic [CntW-1:0]    Depth = CntW'(1) << ADDR_W;
  localparam logic [CntW-1:0]    HsLen = CntW'(HS_LEN);

  logic            r_wr_bank;
  logic [CntW-1:0] r_wr_cnt;
  logic [CntW-1:0] r_last_len;
  logic            r_ovf;
  logic [CntW-1:0] r_rd_cnt;
  logic            r_vga_line;
  logic            r_out_vld;
  logic            r_vga_hs;

  logic            w_wr_full;
  logic            w_we;
  logic            w_wr_bank;
  logic [ADDR_W-1:0] w_wr_lo;
  logic [ADDR_W:0] w_waddr;
  logic            w_rd_act;
  logic            w_rd_last;
  logic            w_re;
  logic [ADDR_W:0] w_raddr;
  lb_word_t        w_wdata;
  lb_word_t        w_rdata;

  // Write/read strobes and addresses; the line strobe redirects a coincident
  // pixel to address 0 of the freshly toggled bank and suppresses any read.
  always_comb begin
    w_wr_full = (r_wr_cnt == Depth);
    w_we      = i_c3 & (i_tv_line_stb | ~w_wr_full);
    w_wr_bank = r_wr_bank ^ i_tv_line_stb;
    w_wr_lo   = i_tv_line_stb ? '0 : r_wr_cnt[ADDR_W-1:0];
    w_waddr   = {w_wr_bank, w_wr_lo};
    w_wdata   = '{blank: i_tv_blank, pix: i_vplex_in};
    w_rd_act  = (r_rd_cnt < r_last_len);
    w_rd_last = (r_rd_cnt == r_last_len - CntW'(1));
    w_re      = i_f0 & ~i_tv_line_stb & w_rd_act;
    w_raddr   = {~r_wr_bank, r_rd_cnt[ADDR_W-1:0]};
  end

  video_linebuf #(
    .ADDR_W (ADDR_W)
  ) u_linebuf (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Capture side: write counter with saturation, bank toggle, sticky overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_last_len <= '0;
      r_ovf      <= 1'b0;
    end else if (i_tv_line_stb) begin
      r_last_len <= r_wr_cnt;
      r_wr_bank  <= ~r_wr_bank;
      r_wr_cnt   <= i_c3 ? CntW'(1) : '0;
    end else if (i_c3) begin
      if (w_wr_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_wr_cnt <= r_wr_cnt + CntW'(1);
      end
    end
  end

  // Replay side: read counter, replay index, output-valid and hsync flags.
  // r_out_vld marks that the RAM output register holds a pixel of this line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_cnt   <= '0;
      r_vga_line <= 1'b0;
      r_out_vld  <= 1'b0;
      r_vga_hs   <= 1'b0;
    end else if (i_tv_line_stb) begin
      r_rd_cnt   <= '0;
      r_vga_line <= 1'b0;
      r_out_vld  <= 1'b0;
      r_vga_hs   <= 1'b0;
    end else if (i_f0) begin
      r_out_vld <= w_rd_act;
      r_vga_hs  <= w_rd_act & (r_rd_cnt < HsLen);
      if (w_rd_act) begin
        if (w_rd_last && !r_vga_line) begin
          r_rd_cnt   <= '0;
          r_vga_line <= 1'b1;
        end else begin
          // After the second replay's last pixel this parks at last_len
          r_rd_cnt <= r_rd_cnt + CntW'(1);
        end
      end
    end
  end

  // Outputs are forced blank whenever no pixel of this line has been read
  always_comb begin
    o_vgaplex   = r_out_vld ? w_rdata.pix : '0;
    o_vga_blank = r_out_vld ? w_rdata.blank : 1'b1;
    o_vga_line  = r_vga_line;
    o_vga_hs    = r_vga_hs;
    o_ovf       = r_ovf;
  end

endmodule
